// File: rtl/gci_std_display_vram_arbiter_if.sv
// gci_std_display_vram_arbiter_if: ownership handshake, command bus and read return of one VRAM port
interface gci_std_display_vram_arbiter_if #(
  parameter int P_MEM_ADDR_N = 22
);
  logic                    req;
  logic                    ack;
  logic                    finish;
  logic                    ena;
  logic                    rw;
  logic [P_MEM_ADDR_N-1:0] addr;
  logic [31:0]             wdata;
  logic                    cmd_busy;
  logic                    valid;
  logic [31:0]             rdata;
  logic                    rsp_busy;
  logic                    brk;
  modport master (
    output req, finish, ena, rw, addr, wdata, rsp_busy,
    input  ack, cmd_busy, valid, rdata, brk
  );
  modport slave (
    input  req, finish, ena, rw, addr, wdata, rsp_busy,
    output ack, cmd_busy, valid, rdata, brk
  );
endinterface

// File: rtl/gci_std_display_vram_arbiter.sv
// gci_std_display_vram_arbiter: grants one of two requesters ownership of the VRAM port, with IF1 starvation guard
module gci_std_display_vram_arbiter #(
  parameter int P_MEM_ADDR_N    = 22,
  parameter int P_STARVE_LIMIT  = 64,
  parameter int P_IF1_MAX_BURST = 16
) (
  input logic iCLOCK,
  input logic inRESET,
  input logic iRESET_SYNC,
  gci_std_display_vram_arbiter_if.slave  if0,
  gci_std_display_vram_arbiter_if.slave  if1,
  gci_std_display_vram_arbiter_if.master vram
);
  localparam int BW = $clog2(P_IF1_MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(P_IF1_MAX_BURST);
  localparam logic [7:0] STARVE_MAX = 8'(P_STARVE_LIMIT);
  typedef enum logic [2:0] {IDLE, ARB_WAIT, OWN0, OWN1, DRAIN} state_t;
  state_t state;
  logic win;
  logic [4:0] rd_cnt;
  logic [7:0] starve_cnt;
  logic [BW-1:0] burst_cnt;
  logic ack0_q, ack1_q, arbit_req_q, arbit_fin_q;
  logic own, route, sat, accept, own_busy, rd_inc, rd_dec, if1_owner, owner_fin, win_next;
  // command path follows the owner; read return follows the owner until the drain completes
  always_comb begin
    own       = state == OWN0 || state == OWN1;
    route     = own || state == DRAIN;
    sat       = rd_cnt == 5'd31;
    own_busy  = vram.cmd_busy || sat;
    accept    = vram.ena && !vram.cmd_busy;
    rd_inc    = accept && !vram.rw;
    rd_dec    = route && vram.valid && !vram.rsp_busy && rd_cnt != 5'd0;
    if1_owner = route && win;
    owner_fin = win ? if1.finish : if0.finish;
    win_next  = if1.req && (starve_cnt == STARVE_MAX || !if0.req);
  end
  assign vram.req      = arbit_req_q;
  assign vram.finish   = arbit_fin_q;
  assign vram.ena      = own && !sat && (win ? if1.ena : if0.ena);
  assign vram.rw       = own && (win ? if1.rw : if0.rw);
  assign vram.addr     = own ? (win ? if1.addr : if0.addr) : '0;
  assign vram.wdata    = own ? (win ? if1.wdata : if0.wdata) : '0;
  assign vram.rsp_busy = route && (win ? if1.rsp_busy : if0.rsp_busy);
  assign if0.ack       = ack0_q;
  assign if1.ack       = ack1_q;
  assign if0.cmd_busy  = (own && !win) ? own_busy : 1'b1;
  assign if1.cmd_busy  = (own && win) ? own_busy : 1'b1;
  assign if0.valid     = route && !win && vram.valid;
  assign if1.valid     = route && win && vram.valid;
  assign if0.rdata     = (route && !win) ? vram.rdata : '0;
  assign if1.rdata     = (route && win) ? vram.rdata : '0;
  assign if0.brk       = 1'b0;
  assign if1.brk       = state == OWN1 && (if0.req || burst_cnt == BURST_MAX);
  // ownership FSM with its grant/finish pulses and the read, starvation and burst counters
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state       <= IDLE;
      win         <= 1'b0;
      rd_cnt      <= '0;
      starve_cnt  <= '0;
      burst_cnt   <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      arbit_req_q <= 1'b0;
      arbit_fin_q <= 1'b0;
    end else if (iRESET_SYNC) begin
      state       <= IDLE;
      win         <= 1'b0;
      rd_cnt      <= '0;
      starve_cnt  <= '0;
      burst_cnt   <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      arbit_req_q <= 1'b0;
      arbit_fin_q <= 1'b0;
    end else begin
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      arbit_fin_q <= 1'b0;
      rd_cnt      <= rd_cnt + 5'(rd_inc) - 5'(rd_dec);
      if (accept && state == OWN1 && burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
      if (if1.req && !if1_owner && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 8'd1;
      case (state)
        IDLE: if (if0.req || if1.req) begin
          win         <= win_next;
          arbit_req_q <= 1'b1;
          state       <= ARB_WAIT;
        end
        ARB_WAIT: if (vram.ack) begin
          arbit_req_q <= 1'b0;
          ack0_q      <= !win;
          ack1_q      <= win;
          state       <= win ? OWN1 : OWN0;
          if (win) begin
            starve_cnt <= '0;
            burst_cnt  <= '0;
          end
        end
        OWN0, OWN1: if (owner_fin) state <= DRAIN;
        DRAIN: if (rd_cnt == 5'd0) begin
          state       <= IDLE;
          arbit_fin_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/gci_std_display_vram_arbiter.md
GCI_STD_DISPLAY_VRAM_ARBITER -- requirements
Module: gci_std_display_vram_arbiter

Interface
REQ-001 Parameter P_MEM_ADDR_N, default 22, VRAM word-address width.
REQ-002 Parameter P_STARVE_LIMIT, default 64, cycles IF1 may wait before it is forced to win arbitration.
REQ-003 Parameter P_IF1_MAX_BURST, default 16, IF1 accepted commands per grant before a break is requested.
REQ-004 Clock and reset: one clock, iCLOCK; reset is asynchronous and active-low, inRESET.
REQ-005 iRESET_SYNC  in  1  synchronous reset, same effect as inRESET.
REQ-006 iIFn_REQ / oIFn_ACK / iIFn_FINISH (n=0,1)  in/out/in  1 each  ownership request, grant, release.
REQ-007 iIFn_ENA, iIFn_RW, iIFn_ADDR, iIFn_DATA  in  1/1/P_MEM_ADDR_N/32  command; RW 1=write.
REQ-008 oIFn_BUSY  out  1  command back-pressure; oIFn_VALID, oIFn_DATA  out  1/32  read return.
REQ-009 iIFn_BUSY  in  1  requester cannot accept read data; oIF1_BREAK  out  1  asks IF1 to finish.
REQ-010 oVRAM_ARBIT_REQ/iVRAM_ARBIT_ACK/oVRAM_ARBIT_FINISH, oVRAM_ENA, iVRAM_BUSY, oVRAM_RW, oVRAM_ADDR[P_MEM_ADDR_N], oVRAM_DATA[32], iVRAM_VALID, oVRAM_BUSY, iVRAM_DATA[32]: downstream VRAM port.

Function
REQ-011 FSM states: IDLE, ARB_WAIT, OWN0, OWN1, DRAIN; one state register.
REQ-012 IDLE: any iIFn_REQ -> assert oVRAM_ARBIT_REQ, latch winner, go ARB_WAIT next cycle.
REQ-013 Winner: IF0 if iIF0_REQ, unless starvation counter = P_STARVE_LIMIT, then IF1; winner fixed once latched.
REQ-014 ARB_WAIT: hold oVRAM_ARBIT_REQ until iVRAM_ARBIT_ACK; then oIFn_ACK pulses 1 cycle for winner, go OWNn.
REQ-015 OWNn: owner's ENA/RW/ADDR/DATA pass combinationally to oVRAM_*; non-owner's oIF_BUSY = 1, its ENA ignored.
REQ-016 Owner oIFn_BUSY = iVRAM_BUSY; a command is accepted when iIFn_ENA && !iVRAM_BUSY.
REQ-017 iVRAM_VALID/iVRAM_DATA route to the owner (or drained owner) only; oVRAM_BUSY = iIFn_BUSY of that owner.
REQ-018 Outstanding-read counter, 5 bits: +1 on accepted read, -1 on iVRAM_VALID && !oVRAM_BUSY, both same cycle = no change; saturates at 31 with owner BUSY forced high.
REQ-019 iIFn_FINISH in OWNn -> DRAIN; DRAIN -> IDLE with 1-cycle oVRAM_ARBIT_FINISH pulse when counter = 0.
REQ-020 Starvation counter, 8 bits: increments each cycle iIF1_REQ high and IF1 not owner; clears on IF1 ACK; saturates at P_STARVE_LIMIT.
REQ-021 IF1 burst counter clears on IF1 ACK, +1 per accepted IF1 command, saturates at P_IF1_MAX_BURST.
REQ-022 oIF1_BREAK = 1 in OWN1 when iIF0_REQ or burst counter = P_IF1_MAX_BURST; IF1 is never preempted, only asked.
REQ-023 FINISH and ENA same cycle: command accepted, then DRAIN.
REQ-024 FINISH with no prior command: DRAIN one cycle, ARBIT_FINISH pulse, IDLE.
REQ-025 REQ dropped during ARB_WAIT: grant still completes; requester must FINISH.
REQ-026 iVRAM_VALID in IDLE: discarded, no oIFn_VALID.

Reset
REQ-027 On inRESET low (async) or iRESET_SYNC high (sync): state IDLE, all counters 0, winner IF0.
REQ-028 Reset values: oVRAM_ARBIT_REQ 0, oVRAM_ARBIT_FINISH 0, oVRAM_ENA 0, oVRAM_RW 0, oVRAM_ADDR 0, oVRAM_DATA 0, oVRAM_BUSY 0, oIFn_ACK 0, oIFn_VALID 0, oIFn_DATA 0, oIFn_BUSY 1, oIF1_BREAK 0.
REQ-029 Reset mid-transaction drops ownership without ARBIT_FINISH; in-flight data discarded.

Verification
REQ-030 IF0 and IF1 REQ same cycle, ACK after 3 cycles -> oIF0_ACK only; IF1 starvation counter = 4 at IF0 ACK.
REQ-031 IF0 issues 4 reads, FINISH, VALID returned 2 cycles later each -> DRAIN until 4th VALID, then ARBIT_FINISH 1 cycle, IDLE.
REQ-032 IF1 owner, 16 writes accepted -> oIF1_BREAK rises cycle after 16th; IF1 FINISH -> IDLE.
REQ-033 IF0 REQ held continuously, IF1 REQ held, P_STARVE_LIMIT=8 -> IF1 wins next arbitration after counter reaches 8.
REQ-034 iVRAM_BUSY high during owner ENA -> oIFn_BUSY 1, no counter change; release -> accepted.
REQ-035 inRESET pulse in OWN1 with 3 reads outstanding -> all outputs at REQ-028 values, counters 0, subsequent VALID ignored.
